// File: rtl/pipe_dest_tracker_pkg.sv
// Shared types for the pipeline destination tracker: the register-number type,
// the packed per-stage slot record, slot indices and small helper functions.
package pipe_dest_tracker_pkg;

    // Architectural register number; register 0 doubles as "no writer".
    typedef logic [4:0] regbits_t;

    // Everything downstream hazard logic needs to know about one in-flight instruction.
    typedef struct packed {
        logic     valid;
        regbits_t rd;
        logic     regwr;
        logic     memren;
        logic     memwen;
        logic     beq;
        logic     bne;
        logic     j;
        logic     jr;
    } stage_t;

    // A bubble is an all-zero slot.
    localparam stage_t STAGE_BUBBLE = '0;

    localparam regbits_t REG_NONE = 5'd0;

    // Slot ordering used for the replicated slot instances.
    localparam int NUM_SLOTS = 3;
    localparam int SLOT_E    = 0;
    localparam int SLOT_M    = 1;
    localparam int SLOT_W    = 2;

    // Destination a slot advertises to the forwarding/hazard logic.
    function automatic regbits_t slot_dest(input stage_t s);
        return (s.valid && s.regwr) ? s.rd : REG_NONE;
    endfunction

    // Saturating increment for the optional event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot register holding a stage_t. Reset beats flush, flush beats
// load, otherwise the slot holds its contents.
module pipe_stage_slot
    import pipe_dest_tracker_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   flush_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t state_q;
    stage_t state_d;

    // Next state: flush wins over load so a squashed instruction never enters.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = STAGE_BUBBLE;
        end else if (load_i) begin
            state_d = d_i;
        end
    end

    // Slot register with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STAGE_BUBBLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign q_o = state_q;

endmodule

// File: rtl/pipe_dest_tracker.sv
// Pipeline destination tracker: follows decode-stage instructions through the
// execute (E), memory (M) and writeback (W) slots and publishes their
// destination registers and control flags to the hazard/forwarding logic.
// Optional build macro PERF_CNT_EN adds saturating stall/flush event counters.
module pipe_dest_tracker
    import pipe_dest_tracker_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_regwr,
    input  logic       id_memren,
    input  logic       id_memwen,
    input  logic       id_beq,
    input  logic       id_bne,
    input  logic       id_j,
    input  logic       id_jr,
    input  logic       alu_zero,
    input  logic       execute_en,
    input  logic       memory_en,
    input  logic       ddeassert,
    input  logic       edeassert,
    input  logic       mdeassert,
    output logic [4:0] read1,
    output logic [4:0] read2,
    output logic [4:0] write1,
    output logic [4:0] write2,
    output logic [4:0] write3,
    output logic       memREN,
    output logic       memWEN,
    output logic       beq,
    output logic       bne,
    output logic       j,
    output logic       jr,
    output logic       zero
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    // A decode instruction is real only if it is valid and not being squashed.
    logic dec_live;
    assign dec_live = id_valid & ~ddeassert;

    stage_t                 dec_stage;
    stage_t                 slot_d [NUM_SLOTS];
    stage_t                 slot_q [NUM_SLOTS];
    logic   [NUM_SLOTS-1:0] slot_load;
    logic   [NUM_SLOTS-1:0] slot_flush;

    // Pack the decode fields; a squashed or empty decode enters E as a full bubble.
    always_comb begin
        dec_stage = STAGE_BUBBLE;
        if (dec_live) begin
            dec_stage.valid  = 1'b1;
            dec_stage.rd     = id_rd;
            dec_stage.regwr  = id_regwr;
            dec_stage.memren = id_memren;
            dec_stage.memwen = id_memwen;
            dec_stage.beq    = id_beq;
            dec_stage.bne    = id_bne;
            dec_stage.j      = id_j;
            dec_stage.jr     = id_jr;
        end
    end

    // Slot chaining: W takes the pre-edge M value, so an M flush in the same
    // cycle still lets the instruction leaving M reach W.
    always_comb begin
        slot_d[SLOT_E] = dec_stage;
        slot_d[SLOT_M] = slot_q[SLOT_E];
        slot_d[SLOT_W] = slot_q[SLOT_M];

        slot_load          = '0;
        slot_load[SLOT_E]  = execute_en;
        slot_load[SLOT_M]  = memory_en;
        slot_load[SLOT_W]  = memory_en;

        slot_flush         = '0;
        slot_flush[SLOT_E] = edeassert;
        slot_flush[SLOT_M] = mdeassert;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            pipe_stage_slot u_slot (
                .clk     (CLK),
                .rst     (RST),
                .load_i  (slot_load[gi]),
                .flush_i (slot_flush[gi]),
                .d_i     (slot_d[gi]),
                .q_o     (slot_q[gi])
            );
        end
    endgenerate

    // Decode-stage sources are combinational and zeroed when decode is not live.
    assign read1 = dec_live ? id_rs : REG_NONE;
    assign read2 = dec_live ? id_rt : REG_NONE;

    // Published destinations; register 0 means no writer in that slot.
    assign write1 = slot_dest(slot_q[SLOT_E]);
    assign write2 = slot_dest(slot_q[SLOT_M]);
    assign write3 = slot_dest(slot_q[SLOT_W]);

    // Memory-slot access flags.
    assign memREN = slot_q[SLOT_M].valid & slot_q[SLOT_M].memren;
    assign memWEN = slot_q[SLOT_M].valid & slot_q[SLOT_M].memwen;

    // Execute-slot control-flow flags; zero passes straight through.
    assign beq  = slot_q[SLOT_E].valid & slot_q[SLOT_E].beq;
    assign bne  = slot_q[SLOT_E].valid & slot_q[SLOT_E].bne;
    assign j    = slot_q[SLOT_E].valid & slot_q[SLOT_E].j;
    assign jr   = slot_q[SLOT_E].valid & slot_q[SLOT_E].jr;
    assign zero = alu_zero;

`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;

    // Count cycles where execute is stalled and cycles carrying any E/M flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!execute_en) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (edeassert | mdeassert) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed self-checking bench for pipe_dest_tracker. Also exercises the
// optional counters when built with PERF_CNT_EN.
module tb_pipe_dest_tracker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwr, id_memren, id_memwen;
    logic       id_beq, id_bne, id_j, id_jr;
    logic       alu_zero;
    logic       execute_en, memory_en, ddeassert, edeassert, mdeassert;
    logic [4:0] read1, read2, write1, write2, write3;
    logic       memREN, memWEN, beq, bne, j, jr, zero;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;

    pipe_dest_tracker dut (
        .CLK        (CLK),
        .RST        (RST),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_regwr   (id_regwr),
        .id_memren  (id_memren),
        .id_memwen  (id_memwen),
        .id_beq     (id_beq),
        .id_bne     (id_bne),
        .id_j       (id_j),
        .id_jr      (id_jr),
        .alu_zero   (alu_zero),
        .execute_en (execute_en),
        .memory_en  (memory_en),
        .ddeassert  (ddeassert),
        .edeassert  (edeassert),
        .mdeassert  (mdeassert),
        .read1      (read1),
        .read2      (read2),
        .write1     (write1),
        .write2     (write2),
        .write3     (write3),
        .memREN     (memREN),
        .memWEN     (memWEN),
        .beq        (beq),
        .bne        (bne),
        .j          (j),
        .jr         (jr),
        .zero       (zero)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    // Advance one clock and settle 1ns past the edge; one line per cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b ex=%0b mem=%0b w1=%0d w2=%0d w3=%0d mren=%0b mwen=%0b beq=%0b",
                 cyc, RST, execute_en, memory_en, write1, write2, write3, memREN, memWEN, beq);
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_regwr = 0; id_memren = 0; id_memwen = 0;
        id_beq = 0; id_bne = 0; id_j = 0; id_jr = 0;
        alu_zero = 0;
        execute_en = 0; memory_en = 0;
        ddeassert = 0; edeassert = 0; mdeassert = 0;
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        set_idle();
        RST = 0;
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 1; id_rd = 5'd3;
        tick();
        tick();
        // reset with every enable, load and flag asserted
        RST = 1; id_rd = 5'd8; id_beq = 1; id_memren = 1;
        edeassert = 0; mdeassert = 0;
        tick();
        checks++; if (write1 !== 5'd0) begin failures++; $display("FAIL reset_w1 got=%0d exp=0", write1); end
        checks++; if (write2 !== 5'd0) begin failures++; $display("FAIL reset_w2 got=%0d exp=0", write2); end
        checks++; if (write3 !== 5'd0) begin failures++; $display("FAIL reset_w3 got=%0d exp=0", write3); end
        checks++; if (memREN !== 1'b0) begin failures++; $display("FAIL reset_memren got=%0b exp=0", memREN); end
        checks++; if (beq !== 1'b0) begin failures++; $display("FAIL reset_beq got=%0b exp=0", beq); end
`ifdef PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stallcnt got=%0d exp=0", stall_cnt); end
`endif
        RST = 0;
    endtask

    task automatic test_flow();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 1; id_rd = 5'd8;
        tick();
        checks++; if (write1 !== 5'd8) begin failures++; $display("FAIL flow_w1 got=%0d exp=8", write1); end
        checks++; if (write2 !== 5'd0) begin failures++; $display("FAIL flow_w2_early got=%0d exp=0", write2); end
        id_valid = 0;
        tick();
        checks++; if (write1 !== 5'd0) begin failures++; $display("FAIL flow_w1_bubble got=%0d exp=0", write1); end
        checks++; if (write2 !== 5'd8) begin failures++; $display("FAIL flow_w2 got=%0d exp=8", write2); end
        tick();
        checks++; if (write3 !== 5'd8) begin failures++; $display("FAIL flow_w3 got=%0d exp=8", write3); end
        checks++; if (write2 !== 5'd0) begin failures++; $display("FAIL flow_w2_drain got=%0d exp=0", write2); end
    endtask

    task automatic test_stall();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 1;
        id_rd = 5'd7; tick();
        id_rd = 5'd6; tick();
        id_rd = 5'd5; tick();
        execute_en = 0; memory_en = 0; id_rd = 5'd12;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (write1 !== 5'd5) begin failures++; $display("FAIL stall_w1 k=%0d got=%0d exp=5", k, write1); end
            checks++; if (write2 !== 5'd6) begin failures++; $display("FAIL stall_w2 k=%0d got=%0d exp=6", k, write2); end
            checks++; if (write3 !== 5'd7) begin failures++; $display("FAIL stall_w3 k=%0d got=%0d exp=7", k, write3); end
        end
`ifdef PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 1;
        id_rd = 5'd4; tick();
        id_rd = 5'd9; tick();
        edeassert = 1; mdeassert = 1;
        tick();
        checks++; if (write1 !== 5'd0) begin failures++; $display("FAIL flush_w1 got=%0d exp=0", write1); end
        checks++; if (write2 !== 5'd0) begin failures++; $display("FAIL flush_w2 got=%0d exp=0", write2); end
        checks++; if (write3 !== 5'd4) begin failures++; $display("FAIL flush_w3 got=%0d exp=4", write3); end
`ifdef PERF_CNT_EN
        checks++; if (flush_cnt !== 32'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", flush_cnt); end
`endif
        edeassert = 0; mdeassert = 0;
    endtask

    task automatic test_gating();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 0; id_rd = 5'd7;
        tick();
        checks++; if (write1 !== 5'd0) begin failures++; $display("FAIL gate_regwr got=%0d exp=0", write1); end
        id_memren = 1; id_memwen = 0;
        tick();
        checks++; if (memREN !== 1'b0) begin failures++; $display("FAIL gate_memren_1cyc got=%0b exp=0", memREN); end
        id_memren = 0; id_memwen = 1;
        tick();
        checks++; if (memREN !== 1'b1) begin failures++; $display("FAIL gate_memren_2cyc got=%0b exp=1", memREN); end
        checks++; if (memWEN !== 1'b0) begin failures++; $display("FAIL gate_memwen_early got=%0b exp=0", memWEN); end
        id_memwen = 0;
        tick();
        checks++; if (memREN !== 1'b0) begin failures++; $display("FAIL gate_memren_3cyc got=%0b exp=0", memREN); end
        checks++; if (memWEN !== 1'b1) begin failures++; $display("FAIL gate_memwen got=%0b exp=1", memWEN); end
        // read ports follow decode combinationally
        id_rs = 5'd3; id_rt = 5'd4; ddeassert = 0;
        #1;
        checks++; if (read1 !== 5'd3) begin failures++; $display("FAIL gate_read1 got=%0d exp=3", read1); end
        checks++; if (read2 !== 5'd4) begin failures++; $display("FAIL gate_read2 got=%0d exp=4", read2); end
        ddeassert = 1; id_regwr = 1; id_rd = 5'd10; id_beq = 1;
        #1;
        checks++; if (read1 !== 5'd0) begin failures++; $display("FAIL gate_read1_dd got=%0d exp=0", read1); end
        checks++; if (read2 !== 5'd0) begin failures++; $display("FAIL gate_read2_dd got=%0d exp=0", read2); end
        tick();
        checks++; if (write1 !== 5'd0) begin failures++; $display("FAIL gate_dd_w1 got=%0d exp=0", write1); end
        checks++; if (beq !== 1'b0) begin failures++; $display("FAIL gate_dd_beq got=%0b exp=0", beq); end
        ddeassert = 0; id_valid = 0;
        #1;
        checks++; if (read1 !== 5'd0) begin failures++; $display("FAIL gate_read1_invalid got=%0d exp=0", read1); end
    endtask

    task automatic test_branch();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_beq = 1;
        tick();
        checks++; if (beq !== 1'b1) begin failures++; $display("FAIL br_beq got=%0b exp=1", beq); end
        checks++; if (bne !== 1'b0) begin failures++; $display("FAIL br_bne got=%0b exp=0", bne); end
        id_beq = 0; id_jr = 1;
        tick();
        checks++; if (jr !== 1'b1) begin failures++; $display("FAIL br_jr got=%0b exp=1", jr); end
        checks++; if (beq !== 1'b0) begin failures++; $display("FAIL br_beq_clear got=%0b exp=0", beq); end
        id_jr = 0; id_j = 1; id_valid = 0;
        tick();
        checks++; if (j !== 1'b0) begin failures++; $display("FAIL br_j_invalid got=%0b exp=0", j); end
        alu_zero = 1;
        #1;
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL br_zero_hi got=%0b exp=1", zero); end
        alu_zero = 0;
        #1;
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL br_zero_lo got=%0b exp=0", zero); end
        id_j = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        execute_en = 1; memory_en = 1;
        id_valid = 1; id_regwr = 1;
        id_rd = 5'd1; tick();
        // E overwritten while M holds: no protection in the tracker
        id_rd = 5'd2; memory_en = 0; tick();
        checks++; if (write1 !== 5'd2) begin failures++; $display("FAIL b2b_overwrite_w1 got=%0d exp=2", write1); end
        checks++; if (write2 !== 5'd0) begin failures++; $display("FAIL b2b_hold_w2 got=%0d exp=0", write2); end
        memory_en = 1;
        id_rd = 5'd3; tick();
        id_rd = 5'd4; tick();
        checks++; if (write1 !== 5'd4) begin failures++; $display("FAIL b2b_w1 got=%0d exp=4", write1); end
        checks++; if (write2 !== 5'd3) begin failures++; $display("FAIL b2b_w2 got=%0d exp=3", write2); end
        checks++; if (write3 !== 5'd2) begin failures++; $display("FAIL b2b_w3 got=%0d exp=2", write3); end
        // reset while stalled discards everything held
        execute_en = 0; memory_en = 0;
        tick();
        RST = 1; tick(); RST = 0;
        checks++; if ({write1, write2, write3} !== 15'd0) begin failures++; $display("FAIL b2b_reset_stall got=%0h exp=0", {write1, write2, write3}); end
    endtask

    initial begin
        set_idle();
        RST = 1;
        test_reset();
        test_flow();
        test_stall();
        test_flush();
        test_gating();
        test_branch();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_dest_tracker.md
PIPE_DEST_TRACKER -- requirements
Module: pipe_dest_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK only.
REQ-002 CLK  in  1  system clock.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_rs, id_rt  in  5 each  decode source register fields.
REQ-006 id_rd  in  5  decode destination register.
REQ-007 id_regwr, id_memren, id_memwen  in  1 each  decode control bits.
REQ-008 id_beq, id_bne, id_j, id_jr  in  1 each  decode branch/jump bits.
REQ-009 alu_zero  in  1  ALU zero flag from execute.
REQ-010 execute_en, memory_en, ddeassert, edeassert, mdeassert  in  1 each  hazard unit stage enables and flushes.
REQ-011 read1, read2  out  5 each  decode-stage source registers.
REQ-012 write1, write2, write3  out  5 each  destinations in execute, memory and writeback slots.
REQ-013 memREN, memWEN  out  1 each  memory-slot load/store flags.
REQ-014 beq, bne, j, jr, zero  out  1 each  execute-slot branch/jump flags and zero flag.

Function
REQ-015 The block SHALL keep three slots, E, M and W; each slot holds {valid, rd, regwr, memren, memwen, beq, bne, j, jr}.
REQ-016 Slot E: edeassert=1 SHALL clear it to a bubble (all fields 0); else execute_en=1 SHALL load the decode inputs, with valid = id_valid & ~ddeassert; else E SHALL hold.
REQ-017 Slot M: mdeassert=1 SHALL clear it; else memory_en=1 SHALL load E; else M SHALL hold.
REQ-018 Slot W: memory_en=1 SHALL load the pre-edge M value, including when mdeassert=1 in the same cycle; else W SHALL hold.
REQ-019 A flush SHALL take priority over a load in the same cycle.
REQ-020 writeN SHALL equal slot.rd when slot.valid & slot.regwr, and 5'd0 otherwise; register 0 SHALL always mean "no writer".
REQ-021 read1/read2 SHALL combinationally equal id_rs/id_rt when id_valid & ~ddeassert, and 0 otherwise.
REQ-022 memREN/memWEN SHALL be M.memren/M.memwen gated by M.valid.
REQ-023 beq/bne/j/jr SHALL be E fields gated by E.valid; zero SHALL pass alu_zero through combinationally.
REQ-024 Register outputs SHALL have one-cycle latency from load; combinational outputs SHALL have zero latency.
REQ-025 The block SHALL NOT protect against overwrite: execute_en=1 with memory_en=0 SHALL still load E, and resolving this is the hazard unit's duty.

Reset
REQ-026 RST=1 SHALL clear all slots to bubbles, so that write1..3, memREN, memWEN, beq, bne, j and jr read 0 on the next cycle.
REQ-027 RST SHALL override all enables and flushes in the same cycle.
REQ-028 Reset mid-stall SHALL discard all held slots.

Configuration
REQ-029 With PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
REQ-030 stall_cnt SHALL increment when execute_en=0.
REQ-031 flush_cnt SHALL increment by 1 in any cycle with edeassert | mdeassert.
REQ-032 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without PERF_CNT_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 The shared package SHALL hold regbits_t (5-bit) and the packed slot struct stage_t.
REQ-035 The block SHALL contain one sub-module, pipe_stage_slot (load/flush/hold register for a stage_t), instantiated three times.

Verification
REQ-036 Reset: assert RST with all enables at 1 -> next cycle write1..3=0, memREN=0, beq=0.
REQ-037 Flow: id_rd=8, id_regwr=1, id_valid=1, all enables 1 -> write1=8, then write2=8, then write3=8 on successive cycles.
REQ-038 Stall: load rd=5, then execute_en=memory_en=0 for 3 cycles -> write1 holds 5 and write2/write3 hold; with PERF_CNT_EN, stall_cnt=3.
REQ-039 Flush collision: edeassert=1 and execute_en=1 with id_rd=9 -> write1=0 next cycle; mdeassert=1 and memory_en=1 with M rd=4 -> write2=0 and write3=4.
REQ-040 Gating: id_regwr=0 with rd=7 -> write1=0; id_memren=1 -> memREN=1 exactly two cycles later; ddeassert=1 -> read1=read2=0 and the E slot loads as a bubble.
